// File: rtl/keycode_pkg.sv
// Shared HID keycode constants, decoder FSM states and the event record
// passed from the keycode filter into the event FIFO.
package keycode_pkg;

   localparam logic [7:0] KC_NONE  = 8'h00;
   localparam logic [7:0] KC_W     = 8'h1A;
   localparam logic [7:0] KC_A     = 8'h04;
   localparam logic [7:0] KC_S     = 8'h16;
   localparam logic [7:0] KC_D     = 8'h07;
   localparam logic [7:0] KC_SPACE = 8'h2C;

   typedef enum logic [1:0] {
      S_FILTER,
      S_PUSH_REL,
      S_PUSH_PRS
   } state_t;

   typedef struct packed {
      logic [7:0] code;
      logic       press;
   } kc_event_t;

   // Held bitmap order is {space, D, S, A, W}.
   function automatic logic [4:0] held_decode(input logic [7:0] code);
      logic [4:0] h;
      h = '0;
      case (code)
         KC_W:     h = 5'b00001;
         KC_A:     h = 5'b00010;
         KC_S:     h = 5'b00100;
         KC_D:     h = 5'b01000;
         KC_SPACE: h = 5'b10000;
         default:  h = '0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/keycode_event_fifo.sv
// First-word-fall-through event FIFO; a push while full succeeds only when
// a pop happens in the same cycle.
module keycode_event_fifo
   import keycode_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic      Clk,
   input  logic      Reset,
   input  logic      push,
   input  kc_event_t push_data,
   input  logic      pop,
   output kc_event_t head,
   output logic      empty,
   output logic      full
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   kc_event_t   mem_q [DEPTH];
   kc_event_t   mem_d [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/keycode_event_decoder.sv
// Debounces the SoC keycode PIO and turns each stable change into
// release/press events, plus a live held-key bitmap for movement and fire.
module keycode_event_decoder
   import keycode_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 1000,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_press,
   output logic [4:0] held,
   output logic       overflow
);

   localparam int unsigned   CW      = $clog2(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

   logic [7:0]    kc_q, kc_d;
   logic [7:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    stable_q, stable_d;
   logic [7:0]    old_q, old_d;
   logic [4:0]    held_q, held_d;
   logic          overflow_q, overflow_d;
   state_t        state_q, state_d;

   logic          accept;
   logic          push;
   logic          pop;
   kc_event_t     push_ev;
   kc_event_t     head_ev;
   logic          fifo_empty;
   logic          fifo_full;

   assign ev_valid = !fifo_empty;
   assign pop      = ev_valid && ev_ready;
   assign ev_code  = head_ev.code;
   assign ev_press = head_ev.press;
   assign held     = held_q;
   assign overflow = overflow_q;

   // Accept also requires the sample to still match, so a value must persist
   // for more than STABLE_CYCLES input cycles to be taken.
   assign accept = (state_q == S_FILTER) && (cnt_q == CNT_MAX) &&
                   (kc_q == cand_q) && (cand_q != stable_q);

   always_comb begin
      kc_d       = keycode;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      stable_d   = stable_q;
      old_d      = old_q;
      held_d     = held_q;
      overflow_d = overflow_q;
      state_d    = state_q;
      push       = 1'b0;
      push_ev    = '0;

      if (kc_q != cand_q) begin
         cand_d = kc_q;
         cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CW'(1);
      end

      case (state_q)
         S_FILTER: begin
            if (accept) begin
               stable_d = cand_q;
               old_d    = stable_q;
               held_d   = held_decode(cand_q);
               state_d  = (stable_q != KC_NONE) ? S_PUSH_REL : S_PUSH_PRS;
            end
         end
         S_PUSH_REL: begin
            push          = 1'b1;
            push_ev.code  = old_q;
            push_ev.press = 1'b0;
            state_d       = (stable_q != KC_NONE) ? S_PUSH_PRS : S_FILTER;
         end
         S_PUSH_PRS: begin
            push          = 1'b1;
            push_ev.code  = stable_q;
            push_ev.press = 1'b1;
            state_d       = S_FILTER;
         end
         default: state_d = S_FILTER;
      endcase

      if (push && fifo_full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         kc_q       <= '0;
         cand_q     <= '0;
         cnt_q      <= '0;
         stable_q   <= '0;
         old_q      <= '0;
         held_q     <= '0;
         overflow_q <= 1'b0;
         state_q    <= S_FILTER;
      end else begin
         kc_q       <= kc_d;
         cand_q     <= cand_d;
         cnt_q      <= cnt_d;
         stable_q   <= stable_d;
         old_q      <= old_d;
         held_q     <= held_d;
         overflow_q <= overflow_d;
         state_q    <= state_d;
      end
   end

   keycode_event_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .push      (push),
      .push_data (push_ev),
      .pop       (pop),
      .head      (head_ev),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

endmodule
